// File: rtl/rs_age_ordered_if.sv
// Dispatch, CDB snoop and result handshake bundle for the age-ordered reservation station.
// The slave modport is the station itself; the master side is the dispatcher/arbiter environment.
interface rs_age_ordered_if #(
    parameter int RS_WIDTH  = 3,
    parameter int RoB_WIDTH = 3,
    parameter int NUM_CDB   = 2
);
    logic                         new_entry_en;
    logic [6:0]                   new_entry_opcode;
    logic [31:0]                  new_entry_Vj;
    logic [31:0]                  new_entry_Vk;
    logic [RoB_WIDTH:0]           new_entry_Qj;
    logic [RoB_WIDTH:0]           new_entry_Qk;
    logic [31:0]                  new_entry_imm;
    logic [RoB_WIDTH-1:0]         new_entry_robEntry;
    logic [31:0]                  new_entry_pc;

    logic [NUM_CDB-1:0]           CDB_update_en;
    logic [NUM_CDB*RoB_WIDTH-1:0] CDB_update_index;
    logic [NUM_CDB*32-1:0]        CDB_update_data;

    logic                         RS_update_en;
    logic                         RS_update_ready;
    logic [RoB_WIDTH-1:0]         RS_update_index;
    logic [31:0]                  RS_update_data;

    logic                         flush_signal;
    logic                         isEmpty;
    logic                         isFull;
    logic [RS_WIDTH:0]            count;

    modport slave (
        input  new_entry_en, new_entry_opcode, new_entry_Vj, new_entry_Vk,
               new_entry_Qj, new_entry_Qk, new_entry_imm, new_entry_robEntry, new_entry_pc,
               CDB_update_en, CDB_update_index, CDB_update_data,
               RS_update_ready, flush_signal,
        output RS_update_en, RS_update_index, RS_update_data,
               isEmpty, isFull, count
    );

    modport master (
        output new_entry_en, new_entry_opcode, new_entry_Vj, new_entry_Vk,
               new_entry_Qj, new_entry_Qk, new_entry_imm, new_entry_robEntry, new_entry_pc,
               CDB_update_en, CDB_update_index, CDB_update_data,
               RS_update_ready, flush_signal,
        input  RS_update_en, RS_update_index, RS_update_data,
               isEmpty, isFull, count
    );
endinterface

// File: rtl/rs_age_ordered.sv
// Reservation station with multi-CDB operand wakeup and oldest-ready-first issue
// into an embedded ALU; results leave through a registered valid/ready stage.
module rs_age_ordered #(
    parameter int RS_WIDTH  = 3,
    parameter int RoB_WIDTH = 3,
    parameter int NUM_CDB   = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    rs_age_ordered_if.slave bus
);
    localparam int RS_SIZE = 1 << RS_WIDTH;
    localparam int TAG_W   = RoB_WIDTH + 1;
    localparam int AGE_W   = RS_WIDTH + 1;
    localparam int CNT_W   = RS_WIDTH + 1;
    localparam logic [TAG_W-1:0] NON_DEP = TAG_W'(1 << RoB_WIDTH);

    logic                 r_valid [RS_SIZE];
    logic [6:0]           r_op    [RS_SIZE];
    logic [31:0]          r_vj    [RS_SIZE];
    logic [31:0]          r_vk    [RS_SIZE];
    logic [TAG_W-1:0]     r_qj    [RS_SIZE];
    logic [TAG_W-1:0]     r_qk    [RS_SIZE];
    logic [31:0]          r_imm   [RS_SIZE];
    logic [RoB_WIDTH-1:0] r_rob   [RS_SIZE];
    logic [31:0]          r_pc    [RS_SIZE];
    logic [AGE_W-1:0]     r_age   [RS_SIZE];

    logic [AGE_W-1:0]     r_seq;
    logic [CNT_W-1:0]     r_count;
    logic                 r_out_en;
    logic [RoB_WIDTH-1:0] r_out_idx;
    logic [31:0]          r_out_data;

    logic [RoB_WIDTH-1:0] w_cdb_idx  [NUM_CDB];
    logic [31:0]          w_cdb_data [NUM_CDB];
    logic [TAG_W-1:0]     w_new_qj;
    logic [TAG_W-1:0]     w_new_qk;
    logic [31:0]          w_new_vj;
    logic [31:0]          w_new_vk;
    logic                 w_full;
    logic                 w_disp;
    logic [RS_WIDTH-1:0]  w_free_idx;
    logic                 w_found;
    logic [RS_WIDTH-1:0]  w_sel_idx;
    logic [AGE_W-1:0]     w_best_dist;
    logic [AGE_W-1:0]     w_dist;
    logic                 w_issue;
    logic [6:0]           w_s_op;
    logic [31:0]          w_s_vj;
    logic [31:0]          w_s_vk;
    logic [31:0]          w_s_imm;
    logic [31:0]          w_s_pc;
    logic [31:0]          w_br_t;
    logic [31:0]          w_br_n;
    logic [31:0]          w_alu;

    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            w_cdb_idx[c]  = bus.CDB_update_index[c*RoB_WIDTH +: RoB_WIDTH];
            w_cdb_data[c] = bus.CDB_update_data[c*32 +: 32];
        end
    end

    // Operands broadcast in the dispatch cycle are captured directly; the tag would otherwise be missed.
    always_comb begin
        w_new_qj = bus.new_entry_Qj;
        w_new_qk = bus.new_entry_Qk;
        w_new_vj = bus.new_entry_Vj;
        w_new_vk = bus.new_entry_Vk;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (bus.CDB_update_en[c] && bus.new_entry_Qj == {1'b0, w_cdb_idx[c]}) begin
                w_new_qj = NON_DEP;
                w_new_vj = w_cdb_data[c];
            end
            if (bus.CDB_update_en[c] && bus.new_entry_Qk == {1'b0, w_cdb_idx[c]}) begin
                w_new_qk = NON_DEP;
                w_new_vk = w_cdb_data[c];
            end
        end
    end

    assign w_full = (r_count == CNT_W'(RS_SIZE));
    assign w_disp = bus.new_entry_en && !w_full;

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = RS_WIDTH'(i);
        end
    end

    // Oldest entry has the smallest (age - seq) modulo 2^AGE_W; twice the entry count keeps it unambiguous.
    always_comb begin
        w_found     = 1'b0;
        w_sel_idx   = '0;
        w_best_dist = '0;
        w_dist      = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_dist = r_age[i] - r_seq;
            if (r_valid[i] && r_qj[i] == NON_DEP && r_qk[i] == NON_DEP &&
                (!w_found || w_dist < w_best_dist)) begin
                w_found     = 1'b1;
                w_sel_idx   = RS_WIDTH'(i);
                w_best_dist = w_dist;
            end
        end
    end

    assign w_issue = w_found && (!r_out_en || bus.RS_update_ready);

    assign w_s_op  = r_op[w_sel_idx];
    assign w_s_vj  = r_vj[w_sel_idx];
    assign w_s_vk  = r_vk[w_sel_idx];
    assign w_s_imm = r_imm[w_sel_idx];
    assign w_s_pc  = r_pc[w_sel_idx];
    assign w_br_t  = w_s_pc + w_s_imm;
    assign w_br_n  = w_s_pc + 32'd4;

    always_comb begin
        w_alu = '0;
        case (w_s_op)
            7'd4:  w_alu = (w_s_vj + w_s_imm) & ~32'd1;
            7'd5:  w_alu = (w_s_vj == w_s_vk) ? w_br_t : w_br_n;
            7'd6:  w_alu = (w_s_vj != w_s_vk) ? w_br_t : w_br_n;
            7'd7:  w_alu = ($signed(w_s_vj) <  $signed(w_s_vk)) ? w_br_t : w_br_n;
            7'd8:  w_alu = ($signed(w_s_vj) >= $signed(w_s_vk)) ? w_br_t : w_br_n;
            7'd9:  w_alu = (w_s_vj <  w_s_vk) ? w_br_t : w_br_n;
            7'd10: w_alu = (w_s_vj >= w_s_vk) ? w_br_t : w_br_n;
            7'd19: w_alu = w_s_vj + w_s_imm;
            7'd20: w_alu = {31'b0, $signed(w_s_vj) < $signed(w_s_imm)};
            7'd21: w_alu = {31'b0, w_s_vj < w_s_imm};
            7'd22: w_alu = w_s_vj ^ w_s_imm;
            7'd23: w_alu = w_s_vj | w_s_imm;
            7'd24: w_alu = w_s_vj & w_s_imm;
            7'd25: w_alu = w_s_vj << w_s_imm[4:0];
            7'd26: w_alu = w_s_vj >> w_s_imm[4:0];
            7'd27: w_alu = $signed(w_s_vj) >>> w_s_imm[4:0];
            7'd28: w_alu = w_s_vj + w_s_vk;
            7'd29: w_alu = w_s_vj - w_s_vk;
            7'd30: w_alu = w_s_vj << w_s_vk[4:0];
            7'd31: w_alu = {31'b0, $signed(w_s_vj) < $signed(w_s_vk)};
            7'd32: w_alu = {31'b0, w_s_vj < w_s_vk};
            7'd33: w_alu = w_s_vj ^ w_s_vk;
            7'd34: w_alu = w_s_vj >> w_s_vk[4:0];
            7'd35: w_alu = $signed(w_s_vj) >>> w_s_vk[4:0];
            7'd36: w_alu = w_s_vj | w_s_vk;
            7'd37: w_alu = w_s_vj & w_s_vk;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_valid[i] <= 1'b0;
                r_op[i]    <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= NON_DEP;
                r_qk[i]    <= NON_DEP;
                r_imm[i]   <= '0;
                r_rob[i]   <= '0;
                r_pc[i]    <= '0;
                r_age[i]   <= '0;
            end
            r_seq      <= '0;
            r_count    <= '0;
            r_out_en   <= 1'b0;
            r_out_idx  <= '0;
            r_out_data <= '0;
        end else if (rdy_in) begin
            if (bus.flush_signal) begin
                for (int i = 0; i < RS_SIZE; i++) r_valid[i] <= 1'b0;
                r_out_en <= 1'b0;
                r_count  <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_disp && w_free_idx == RS_WIDTH'(i)) begin
                        r_valid[i] <= 1'b1;
                        r_op[i]    <= bus.new_entry_opcode;
                        r_vj[i]    <= w_new_vj;
                        r_vk[i]    <= w_new_vk;
                        r_qj[i]    <= w_new_qj;
                        r_qk[i]    <= w_new_qk;
                        r_imm[i]   <= bus.new_entry_imm;
                        r_rob[i]   <= bus.new_entry_robEntry;
                        r_pc[i]    <= bus.new_entry_pc;
                        r_age[i]   <= r_seq;
                    end else if (r_valid[i]) begin
                        if (w_issue && w_sel_idx == RS_WIDTH'(i)) r_valid[i] <= 1'b0;
                        for (int c = 0; c < NUM_CDB; c++) begin
                            if (bus.CDB_update_en[c] && r_qj[i] == {1'b0, w_cdb_idx[c]}) begin
                                r_vj[i] <= w_cdb_data[c];
                                r_qj[i] <= NON_DEP;
                            end
                            if (bus.CDB_update_en[c] && r_qk[i] == {1'b0, w_cdb_idx[c]}) begin
                                r_vk[i] <= w_cdb_data[c];
                                r_qk[i] <= NON_DEP;
                            end
                        end
                    end
                end
                if (w_disp) r_seq <= r_seq + AGE_W'(1);
                if (w_issue) begin
                    r_out_en   <= 1'b1;
                    r_out_idx  <= r_rob[w_sel_idx];
                    r_out_data <= w_alu;
                end else if (r_out_en && bus.RS_update_ready) begin
                    r_out_en <= 1'b0;
                end
                case ({w_disp, w_issue})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.RS_update_en    = r_out_en;
    assign bus.RS_update_index = r_out_idx;
    assign bus.RS_update_data  = r_out_data;
    assign bus.count           = r_count;
    assign bus.isFull          = w_full;
    assign bus.isEmpty         = (r_count == '0);
endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: opcode vector table plus hand sequences for wakeup, bypass, fill, flush and reset.
module tb_rs_age_ordered;
    localparam int RS_WIDTH  = 3;
    localparam int RoB_WIDTH = 3;
    localparam int NUM_CDB   = 2;
    localparam logic [3:0] ND = 4'd8;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks = 0;
    int   failures = 0;
    logic [34:0] exp_q[$];
    vec_t vt[16];

    rs_age_ordered_if #(.RS_WIDTH(RS_WIDTH), .RoB_WIDTH(RoB_WIDTH), .NUM_CDB(NUM_CDB)) bus();

    rs_age_ordered #(.RS_WIDTH(RS_WIDTH), .RoB_WIDTH(RoB_WIDTH), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.vj = vj; v.vk = vk; v.imm = imm; v.pc = pc; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Results are taken at the negedge before the edge where the handshake completes.
    task automatic step();
        logic [34:0] e;
        @(negedge clk_in);
        if (!rst_in && rdy_in && bus.RS_update_en && bus.RS_update_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got idx=%0d data=%h expected=none",
                         bus.RS_update_index, bus.RS_update_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", {29'b0, bus.RS_update_index, bus.RS_update_data}, {29'b0, e});
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] imm,
                        input logic [2:0] rob, input logic [31:0] pc);
        bus.new_entry_en       = 1'b1;
        bus.new_entry_opcode   = op;
        bus.new_entry_Vj       = vj;
        bus.new_entry_Vk       = vk;
        bus.new_entry_Qj       = qj;
        bus.new_entry_Qk       = qk;
        bus.new_entry_imm      = imm;
        bus.new_entry_robEntry = rob;
        bus.new_entry_pc       = pc;
    endtask

    task automatic idle();
        bus.new_entry_en = 1'b0;
    endtask

    task automatic cdb_clear();
        bus.CDB_update_en    = '0;
        bus.CDB_update_index = '0;
        bus.CDB_update_data  = '0;
    endtask

    initial begin
        vt[0]  = mk(7'd19, 32'd5,        32'd0,        32'hFFFFFFFD, 32'h0,   32'd2);
        vt[1]  = mk(7'd7,  32'hFFFFFFFF, 32'd1,        32'd8,        32'h100, 32'h108);
        vt[2]  = mk(7'd9,  32'hFFFFFFFF, 32'd1,        32'd8,        32'h100, 32'h104);
        vt[3]  = mk(7'd35, 32'h80000000, 32'd33,       32'd0,        32'h0,   32'hC0000000);
        vt[4]  = mk(7'd4,  32'h1001,     32'd0,        32'd4,        32'h0,   32'h1004);
        vt[5]  = mk(7'd29, 32'd3,        32'd5,        32'd0,        32'h0,   32'hFFFFFFFE);
        vt[6]  = mk(7'd32, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h0,   32'd1);
        vt[7]  = mk(7'd31, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h0,   32'd0);
        vt[8]  = mk(7'd26, 32'h80000000, 32'd0,        32'h21,       32'h0,   32'h40000000);
        vt[9]  = mk(7'd5,  32'd7,        32'd7,        32'hFFFFFFF0, 32'h200, 32'h1F0);
        vt[10] = mk(7'd10, 32'd1,        32'd2,        32'h10,       32'h40,  32'h44);
        vt[11] = mk(7'd30, 32'd1,        32'd31,       32'd0,        32'h0,   32'h80000000);
        vt[12] = mk(7'd22, 32'hFF,       32'd0,        32'hFFFFFFFF, 32'h0,   32'hFFFFFF00);
        vt[13] = mk(7'd50, 32'd9,        32'd9,        32'd9,        32'h0,   32'd0);
        vt[14] = mk(7'd37, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,   32'hF000);
        vt[15] = mk(7'd8,  32'hFFFFFFFF, 32'd1,        32'd8,        32'h100, 32'h104);

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        disp(7'd0, 32'd0, 32'd0, ND, ND, 32'd0, 3'd0, 32'd0);
        idle();
        cdb_clear();
        bus.RS_update_ready = 1'b1;
        bus.flush_signal    = 1'b0;
        #12;
        chk("reset_en", {63'b0, bus.RS_update_en}, 64'd0);
        chk("reset_count", {60'b0, bus.count}, 64'd0);
        chk("reset_empty", {62'b0, bus.isEmpty, bus.isFull}, 64'd2);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Latency: ready op dispatched at edge N is presented after edge N+1
        disp(7'd19, 32'd5, 32'd0, ND, ND, 32'hFFFFFFFD, 3'd6, 32'd0);
        exp_q.push_back({3'd6, 32'd2});
        step();
        idle();
        chk("lat_edge0_en", {63'b0, bus.RS_update_en}, 64'd0);
        step();
        chk("lat_edge1", {28'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data},
            {28'b0, 1'b1, 3'd6, 32'd2});
        step();
        step();

        for (int i = 0; i < 16; i++) begin
            disp(vt[i].op, vt[i].vj, vt[i].vk, ND, ND, vt[i].imm, 3'(i), vt[i].pc);
            exp_q.push_back({3'(i), vt[i].exp});
            step();
        end
        idle();
        repeat (4) step();
        chk("table_drained", {59'b0, bus.isEmpty, bus.count}, {59'b0, 1'b1, 4'd0});

        // Older entry A waits on tag 2; younger ready B overtakes it
        disp(7'd28, 32'd0, 32'd1, 4'd2, ND, 32'd0, 3'd3, 32'd0);
        step();
        disp(7'd19, 32'd7, 32'd0, ND, ND, 32'd1, 3'd4, 32'd0);
        exp_q.push_back({3'd4, 32'd8});
        exp_q.push_back({3'd3, 32'h11});
        step();
        idle();
        bus.CDB_update_en    = 2'b10;
        bus.CDB_update_index = {3'd2, 3'd0};
        bus.CDB_update_data  = {32'h10, 32'h0};
        step();
        cdb_clear();
        chk("ab_first", {28'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data},
            {28'b0, 1'b1, 3'd4, 32'd8});
        step();
        chk("ab_second", {28'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data},
            {28'b0, 1'b1, 3'd3, 32'h11});
        step();
        step();

        // Dispatch-cycle bypass of Qk from channel 0
        disp(7'd28, 32'd1, 32'd0, ND, 4'd5, 32'd0, 3'd5, 32'd0);
        bus.CDB_update_en    = 2'b01;
        bus.CDB_update_index = {3'd0, 3'd5};
        bus.CDB_update_data  = {32'h0, 32'h100};
        exp_q.push_back({3'd5, 32'h101});
        step();
        idle();
        cdb_clear();
        chk("byp_wait_en", {63'b0, bus.RS_update_en}, 64'd0);
        step();
        chk("byp_issue", {28'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data},
            {28'b0, 1'b1, 3'd5, 32'h101});
        step();
        step();

        // Fill with the output stalled; one extra entry lands in the output register
        bus.RS_update_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            disp(7'd19, 32'(i), 32'd0, ND, ND, 32'h10, 3'(i), 32'd0);
            exp_q.push_back({3'(i), 32'(i) + 32'h10});
            step();
        end
        disp(7'd19, 32'hDEAD, 32'd0, ND, ND, 32'h10, 3'd7, 32'd0);
        step();
        idle();
        chk("full_flags", {59'b0, bus.isFull, bus.count}, {59'b0, 1'b1, 4'd8});
        repeat (3) step();
        chk("stall_hold", {28'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data},
            {28'b0, 1'b1, 3'd0, 32'h10});
        rdy_in = 1'b0;
        bus.RS_update_ready = 1'b1;
        step();
        step();
        chk("freeze_hold", {24'b0, bus.count, bus.RS_update_en, bus.RS_update_data},
            {24'b0, 4'd8, 1'b1, 32'h10});
        rdy_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("drain_en", {63'b0, bus.RS_update_en}, 64'd1);
            step();
        end
        chk("drain_done", {58'b0, bus.RS_update_en, bus.isEmpty, bus.count},
            {58'b0, 1'b0, 1'b1, 4'd0});

        // Flush with ready entries and a same-cycle dispatch
        bus.RS_update_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(7'd19, 32'h40, 32'd0, ND, ND, 32'(i), 3'(i), 32'd0);
            step();
        end
        idle();
        chk("pre_flush", {59'b0, bus.RS_update_en, bus.count}, {59'b0, 1'b1, 4'd2});
        disp(7'd19, 32'h77, 32'd0, ND, ND, 32'd0, 3'd3, 32'd0);
        bus.flush_signal = 1'b1;
        step();
        bus.flush_signal = 1'b0;
        idle();
        chk("post_flush", {58'b0, bus.RS_update_en, bus.isEmpty, bus.count},
            {58'b0, 1'b0, 1'b1, 4'd0});
        bus.RS_update_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flush_quiet", {63'b0, bus.RS_update_en}, 64'd0);
        end

        // Asynchronous reset mid-operation
        bus.RS_update_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(7'd19, 32'h55, 32'd0, ND, ND, 32'd1, 3'(5 + i), 32'd0);
            step();
        end
        idle();
        chk("pre_reset", {24'b0, bus.RS_update_en, bus.count, bus.RS_update_data},
            {24'b0, 1'b1, 4'd2, 32'h56});
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_reset", {24'b0, bus.RS_update_en, bus.RS_update_index, bus.RS_update_data, bus.count},
            64'd0);
        chk("async_reset_empty", {63'b0, bus.isEmpty}, 64'd1);
        step();
        rst_in = 1'b0;
        bus.RS_update_ready = 1'b1;
        repeat (3) step();
        chk("reset_quiet", {63'b0, bus.RS_update_en}, 64'd0);

        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
- Parametrised successor to the single-ALU reservation station.
- Holds up to 2^RS_WIDTH pending ALU/branch/jalr ops and snoops NUM_CDB result buses for operand wakeup.
- Issues the oldest ready entry to an embedded ALU; the registered result goes out on a valid/ready handshake toward the CDB arbiter.
- Sits between the Dispatcher and the CDB arbiter; flushed on branch mispredict.

Parameters:
- RS_WIDTH, 3, log2 of entry count (1..5); RS_SIZE = 1<<RS_WIDTH.
- RoB_WIDTH, 3, RoB index width; NON_DEP = 1<<RoB_WIDTH marks a ready operand.
- NUM_CDB, 2, number of snooped result channels (1..4).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- new_entry_en  in  1  dispatch request
- new_entry_opcode  in  7  internal opcode: jalr=4, beq..bgeu=5..10, addi..srai=19..27, add..andr=28..37
- new_entry_Vj, new_entry_Vk  in  32 each  operand values
- new_entry_Qj, new_entry_Qk  in  RoB_WIDTH+1 each  producer tags; NON_DEP = value valid
- new_entry_imm  in  32  immediate
- new_entry_robEntry  in  RoB_WIDTH  destination RoB slot
- new_entry_pc  in  32  instruction PC
- CDB_update_en  in  NUM_CDB  per-channel broadcast valid
- CDB_update_index  in  NUM_CDB*RoB_WIDTH  packed tags, channel c at [c*RoB_WIDTH +: RoB_WIDTH]
- CDB_update_data  in  NUM_CDB*32  packed data
- RS_update_en  out  1  result valid
- RS_update_ready  in  1  arbiter accepts result
- RS_update_index  out  RoB_WIDTH  RoB slot of result
- RS_update_data  out  32  result
- flush_signal  in  1  discard all contents
- isEmpty, isFull  out  1 each  occupancy flags (combinational from count)
- count  out  RS_WIDTH+1  occupied entries

Behaviour:
- Reset (async): all entries invalid; Qj/Qk=NON_DEP; RS_update_en=0; RS_update_index=0; RS_update_data=0; count=0; age counter=0.
- rdy_in=0 and no reset: no state changes, outputs hold.
- Priority: rst_in > !rdy_in > flush_signal > normal operation.
- Flush: at that edge, invalidate all entries, RS_update_en<=0, count<=0. Dispatch and issue in the same cycle are dropped.
- Dispatch when new_entry_en && !isFull:
  - write the lowest-index free slot and stamp it with a (RS_WIDTH+1)-bit age sequence number.
  - If new_entry_en arrives while isFull, it is ignored; the Dispatcher must not do this.
- Dispatch bypass: if new_entry_Qj/Qk matches any active CDB channel that same cycle, store the CDB data and NON_DEP instead of the tag.
- Wakeup: each valid entry compares Qj/Qk against every active channel. On a match it captures data and sets the tag to NON_DEP at that edge.
  - Tags are unique in flight, so multiple channels never match the same tag.
- Ready: valid && Qj==NON_DEP && Qk==NON_DEP.
- Issue selection: the oldest ready entry, i.e. smallest age distance from the current sequence counter (wrap-safe modulo compare). Selection depends only on registered state, so a dispatched entry is selectable no earlier than the next cycle.
- Output register:
  - Issue fires when a ready entry exists and (!RS_update_en || RS_update_ready).
  - On issue, the entry is freed and the ALU result is written with RS_update_en<=1.
  - If RS_update_en && RS_update_ready and nothing issues, RS_update_en<=0.
  - While RS_update_en && !RS_update_ready, outputs hold stable.
- Latency: dispatch of an already-ready op at edge N gives RS_update_en=1 after edge N+1 (output idle).
- Throughput: one result per cycle while RS_update_ready=1.
- count: +1 on dispatch, -1 on issue; both in the same cycle leave it unchanged. A slot freed by issue is not reused by dispatch in the same cycle.
- ALU arithmetic, 32-bit wrap:
  - jalr: (Vj+imm)&~1.
  - Branches: result = taken ? pc+imm : pc+4. blt/bge compare signed; bltu/bgeu compare unsigned.
  - slt/slti are signed; sltu/sltiu are unsigned, with imm already sign-extended.
  - Shifts use amount[4:0] only; srai/sra are arithmetic.
  - Undefined opcode: result 0, still reported.

Test Plan:
- Reset mid-operation with 3 entries and RS_update_en=1 -> all outputs 0 and count=0 immediately, with no clock edge needed.
- Dispatch addi Vj=5, imm=-3, Qj=NON_DEP at edge 0 -> RS_update_en=1, data=2, index=robEntry after edge 1.
- Dispatch entry A (Qj=2) then B (ready). Channel 1 broadcasts tag 2 with 0x10 one cycle later -> B issues first; A issues next, with Vj=0x10 used.
- Dispatch in the same cycle as a CDB broadcast of its Qk tag (bypass) -> entry issues next cycle with the broadcast value.
- Fill to RS_SIZE with RS_update_ready=0:
  - isFull=1, count=RS_SIZE, and the extra dispatch is ignored.
  - Output holds until ready rises.
  - Then one result per cycle in age order.
- Opcode checks: blt Vj=-1, Vk=1, pc=0x100, imm=8 -> 0x108; bltu same operands -> 0x104; sra 0x80000000 by 33 -> 0xC0000000.
- Flush with ready entries -> next cycle RS_update_en=0, isEmpty=1, and nothing ever issues from those entries.
